frame_write_sequencer: RTL
==========================

// Module: frame_write_sequencer
// PURPOSE
//  Sequences camera pixel writes into the four 320x240 quadrant frame buffers read by the VGA driver.
//  Accepts a 640x480 raster-order RGB444 stream (valid/ready, SOF-tagged) and converts raster position
//  into a one-hot quadrant write enable plus a quadrant-local address. Frame capture is armed by a
//  software enable. Reports frame completion and framing errors. Sits between frame-transfer input and buffer write ports.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line; quadrant width SUB_W = H_ACTIVE/2
//  V_ACTIVE  480  active lines per frame; quadrant height SUB_H = V_ACTIVE/2
//  DATA_W    12   pixel width, {R[3:0],G[3:0],B[3:0]}
//  ADDR_W    17   quadrant address width (SUB_W*SUB_H must be <= 2**ADDR_W)
// PORTS
//  piul1Clock        in   1       single clock, all logic posedge
//  piul1Reset        in   1       synchronous, active-high reset
//  piul1FrameEnable  in   1       level; 1 = capture frames continuously, sampled at frame boundaries
//  piul1PixValid     in   1       input pixel valid
//  piul1PixSof       in   1       first pixel of frame, qualified by PixValid
//  piul12PixData     in   DATA_W  input pixel
//  poul1PixReady     out  1       sequencer can accept a pixel this cycle
//  poul4WEnable      out  4       one-hot quadrant write strobe: bit0 TL, bit1 TR, bit2 BL, bit3 BR
//  poul17WAddr       out  ADDR_W  quadrant-local write address
//  poul12WData       out  DATA_W  write data
//  poul1FrameDone    out  1       1-cycle pulse, last pixel of frame written
//  poul1SofError     out  1       1-cycle pulse, SOF received mid-frame
//  poul1Busy         out  1       1 while in WRITE state
// BEHAVIOUR
//  Reset: state IDLE; col/row counters 0; all outputs 0. Reset mid-frame aborts with no further writes.
//  Accept = PixValid & PixReady. PixReady = 1 in WAIT_SOF and WRITE, 0 in IDLE (combinational from state).
//  States:
//   IDLE     -> WAIT_SOF when FrameEnable=1.
//   WAIT_SOF : accepted pixels without SOF are discarded (no write). Accepted SOF pixel is written
//              at (col,row)=(0,0), counters advance to (1,0), -> WRITE.
//   WRITE    : each accepted pixel is written at (col,row), col++; col wraps at H_ACTIVE-1 -> 0 with row++.
//              On accept of (H_ACTIVE-1,V_ACTIVE-1): counters -> (0,0), FrameDone pulses with that write,
//              next state WAIT_SOF if FrameEnable=1, else IDLE.
//              Accepted SOF in WRITE: SofError pulses, pixel written at (0,0), counters -> (1,0), stay WRITE.
//   FrameEnable=0 mid-frame does not abort; the frame completes.
//  Write outputs are registered; latency 1 cycle from accept to WEnable/WAddr/WData.
//   WEnable=0 on any cycle without an accept that wrote; WAddr/WData hold their last value.
//  Mapping: quadrant = {row >= SUB_H, col >= SUB_W}, WEnable = 1 << quadrant.
//   WAddr = (row mod SUB_H)*SUB_W + (col mod SUB_W). Use incremental counters, no multiplier.
//  Busy = (state==WRITE), registered with the state.
//  Input gaps (PixValid=0) freeze all counters.
//  Simultaneous last pixel and SOF on the same accept: treated as SofError, restart at (0,0); no FrameDone.
// TESTING
//  T1 reset, FrameEnable=1, 307200 gapless pixels, SOF on first, data=idx[11:0].
//     (0,0) -> WEnable=0001 addr 0; (319,239) -> 0001 addr 76799; (320,0) -> 0010 addr 0;
//     (0,240) -> 0100 addr 0; (639,479) -> 1000 addr 76799; FrameDone on that write cycle only.
//  T2 five pixels without SOF, then SOF -> all accepted (Ready=1); no WEnable until SOF pixel (0001 addr 0).
//  T3 SOF at raster (100,5) mid-frame -> SofError 1 cycle; that pixel written 0001 addr 0; next pixel addr 1.
//  T4 random PixValid gaps (~50%) over a full frame -> addresses identical to T1, no writes on gap cycles.
//  T5 FrameEnable=0 at row 200 -> frame completes with FrameDone, then IDLE with Ready=0 and Busy=0.
//  T6 Reset at (10,300) -> next cycle WEnable=0, Busy=0, Ready=0; after re-enable, SOF writes 0001 addr 0.

Source files
------------

// File: rtl/frame_write_sequencer.sv
// Converts a raster-order pixel stream into one-hot quadrant write strobes with quadrant-local addresses.
// Frame capture is armed by FrameEnable; SOF resynchronises the raster counters.
module frame_write_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 17
) (
  input  logic              piul1Clock,
  input  logic              piul1Reset,
  input  logic              piul1FrameEnable,
  input  logic              piul1PixValid,
  input  logic              piul1PixSof,
  input  logic [DATA_W-1:0] piul12PixData,
  output logic              poul1PixReady,
  output logic [3:0]        poul4WEnable,
  output logic [ADDR_W-1:0] poul17WAddr,
  output logic [DATA_W-1:0] poul12WData,
  output logic              poul1FrameDone,
  output logic              poul1SofError,
  output logic              poul1Busy
);

  localparam int SUB_W = H_ACTIVE / 2;
  localparam int SUB_H = V_ACTIVE / 2;
  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = $clog2(V_ACTIVE);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, WRITE = 2'd2} state_t;

  state_t            state_r, nextState_s;
  logic              busy_r;
  logic [COL_W-1:0]  col_r, colNext_s, colLocal_s;
  logic [ROW_W-1:0]  row_r, rowNext_s;
  logic [ADDR_W-1:0] rowBase_r, rowBaseNext_s;
  logic              accept_s, write_s, sofErr_s, frameDone_s;
  logic [1:0]        quad_s;
  logic [3:0]        wEnNext_s;
  logic [ADDR_W-1:0] wAddrNext_s;
  logic [3:0]        wEnable_r;
  logic [ADDR_W-1:0] wAddr_r;
  logic [DATA_W-1:0] wData_r;
  logic              frameDone_r, sofError_r;

  assign poul1PixReady = (state_r != IDLE);
  assign accept_s      = piul1PixValid & poul1PixReady;
  assign colLocal_s    = (col_r >= COL_W'(SUB_W)) ? (col_r - COL_W'(SUB_W)) : col_r;
  assign quad_s        = {row_r >= ROW_W'(SUB_H), col_r >= COL_W'(SUB_W)};

  // State register; Busy tracks the state it is registered with
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s == WRITE);
    end
  end

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (piul1FrameEnable) nextState_s = WAIT_SOF;
        else                  nextState_s = IDLE;
      end
      WAIT_SOF: begin
        if (accept_s && piul1PixSof) nextState_s = WRITE;
        else                         nextState_s = WAIT_SOF;
      end
      WRITE: begin
        if (frameDone_s) nextState_s = piul1FrameEnable ? WAIT_SOF : IDLE;
        else             nextState_s = WRITE;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Write decision and counter advance; the row base steps by SUB_W so no multiplier is needed
  always_comb begin
    write_s       = 1'b0;
    sofErr_s      = 1'b0;
    frameDone_s   = 1'b0;
    wEnNext_s     = 4'b0000;
    wAddrNext_s   = {ADDR_W{1'b0}};
    colNext_s     = col_r;
    rowNext_s     = row_r;
    rowBaseNext_s = rowBase_r;
    if (accept_s && piul1PixSof) begin
      // SOF always restarts the raster, even on the last pixel of a frame
      write_s       = 1'b1;
      sofErr_s      = (state_r == WRITE);
      wEnNext_s     = 4'b0001;
      colNext_s     = COL_W'(1);
      rowNext_s     = {ROW_W{1'b0}};
      rowBaseNext_s = {ADDR_W{1'b0}};
    end else if (accept_s && (state_r == WRITE)) begin
      write_s     = 1'b1;
      wEnNext_s   = 4'b0001 << quad_s;
      wAddrNext_s = rowBase_r + ADDR_W'(colLocal_s);
      if (col_r == COL_W'(H_ACTIVE - 1)) begin
        colNext_s = {COL_W{1'b0}};
        if (row_r == ROW_W'(V_ACTIVE - 1)) begin
          frameDone_s   = 1'b1;
          rowNext_s     = {ROW_W{1'b0}};
          rowBaseNext_s = {ADDR_W{1'b0}};
        end else begin
          rowNext_s     = row_r + ROW_W'(1);
          rowBaseNext_s = (row_r == ROW_W'(SUB_H - 1)) ? {ADDR_W{1'b0}}
                                                       : rowBase_r + ADDR_W'(SUB_W);
        end
      end else begin
        colNext_s = col_r + COL_W'(1);
      end
    end else begin
      write_s = 1'b0;
    end
  end

  // Raster counters
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      col_r     <= {COL_W{1'b0}};
      row_r     <= {ROW_W{1'b0}};
      rowBase_r <= {ADDR_W{1'b0}};
    end else begin
      col_r     <= colNext_s;
      row_r     <= rowNext_s;
      rowBase_r <= rowBaseNext_s;
    end
  end

  // Registered write port and status pulses; address and data hold between writes
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      wEnable_r   <= 4'b0000;
      wAddr_r     <= {ADDR_W{1'b0}};
      wData_r     <= {DATA_W{1'b0}};
      frameDone_r <= 1'b0;
      sofError_r  <= 1'b0;
    end else begin
      if (write_s) begin
        wEnable_r <= wEnNext_s;
        wAddr_r   <= wAddrNext_s;
        wData_r   <= piul12PixData;
      end else begin
        wEnable_r <= 4'b0000;
      end
      frameDone_r <= frameDone_s;
      sofError_r  <= sofErr_s;
    end
  end

  assign poul4WEnable   = wEnable_r;
  assign poul17WAddr    = wAddr_r;
  assign poul12WData    = wData_r;
  assign poul1FrameDone = frameDone_r;
  assign poul1SofError  = sofError_r;
  assign poul1Busy      = busy_r;

endmodule
